// File: rtl/jtframe_joy_serial_if.sv
// jtframe_joy_serial_if: board-pin and joystick-bus signals of the serial joystick reader
interface jtframe_joy_serial_if;
  logic       joy_data;
  logic       joy_clk;
  logic       joy_load;
  logic [5:0] joy1;
  logic [5:0] joy2;
  logic       frame_done;
  modport master (input joy_data, output joy_clk, joy_load, joy1, joy2, frame_done);
  modport slave  (output joy_data, input joy_clk, joy_load, joy1, joy2, frame_done);
endinterface

// File: rtl/jtframe_joy_serial.sv
// jtframe_joy_serial: reads a two-74HC165 chain into two active-low 6-bit joystick buses
// Define JTFRAME_JOY_DEBOUNCE_EN to require two identical frames before an output bit changes.
module jtframe_joy_serial #(
  parameter int CLKDIV = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  jtframe_joy_serial_if.master        bus
);
  typedef enum logic [1:0] {LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;
  state_t      st;
  logic [7:0]  cnt;
  logic [3:0]  idx;
  logic [15:0] sr;
  logic [11:0] smp;
  logic [11:0] nxt;
  logic        last;
  logic        unused_sr;
  assign last      = cnt == 8'(CLKDIV - 1);
  assign smp       = {sr[13], sr[12], sr[8], sr[9], sr[10], sr[11], sr[5], sr[4], sr[0], sr[1], sr[2], sr[3]};
  assign unused_sr = ^{sr[15:14], sr[7:6]};
`ifdef JTFRAME_JOY_DEBOUNCE_EN
  logic [11:0] prev;
  logic [11:0] same;
  assign same = smp ~^ prev;
  assign nxt  = (same & smp) | (~same & {bus.joy2, bus.joy1});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= 12'hFFF;
    else if (st == LATCH) prev <= smp;
`else
  assign nxt = smp;
`endif
  // state names the phase driven onto the pins in the cycle after each edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st             <= LOAD;
      cnt            <= 8'd0;
      idx            <= 4'd0;
      sr             <= 16'hFFFF;
      bus.joy_clk    <= 1'b0;
      bus.joy_load   <= 1'b1;
      bus.joy1       <= 6'h3F;
      bus.joy2       <= 6'h3F;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      cnt            <= last ? 8'd0 : cnt + 8'd1;
      case (st)
        LOAD: begin
          bus.joy_load <= 1'b0;
          bus.joy_clk  <= 1'b0;
          if (last) begin
            idx <= 4'd0;
            st  <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          bus.joy_load <= 1'b1;
          bus.joy_clk  <= 1'b0;
          if (last) begin
            sr[idx] <= bus.joy_data;
            st      <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          bus.joy_clk <= 1'b1;
          if (last) begin
            idx <= idx == 4'd15 ? idx : idx + 4'd1;
            st  <= idx == 4'd15 ? LATCH : SHIFT_LO;
          end
        end
        default: begin
          cnt                  <= 8'd0;
          bus.joy_clk          <= 1'b0;
          bus.frame_done       <= 1'b1;
          {bus.joy2, bus.joy1} <= nxt;
          st                   <= LOAD;
        end
      endcase
    end
endmodule
